// File: rtl/viterbi_acs_if.sv
// Symbol-in / traceback-out bundle between the Viterbi ACS stage and its neighbours.
// The master drives received symbols; the slave (ACS stage) returns handshake and traceback data.
interface viterbi_acs_if #(
    parameter int PM_W = 6
);
    logic            in_valid;
    logic [1:0]      in_sym;
    logic            in_ready;
    logic            en_tbck;
    logic [1:0]      sel_node;
    logic [1:0]      bck_prv_st_00;
    logic [1:0]      bck_prv_st_01;
    logic [1:0]      bck_prv_st_10;
    logic [1:0]      bck_prv_st_11;
    logic [PM_W-1:0] best_metric;

    modport master (
        output in_valid, in_sym,
        input  in_ready, en_tbck, sel_node, best_metric,
        input  bck_prv_st_00, bck_prv_st_01, bck_prv_st_10, bck_prv_st_11
    );

    modport slave (
        input  in_valid, in_sym,
        output in_ready, en_tbck, sel_node, best_metric,
        output bck_prv_st_00, bck_prv_st_01, bck_prv_st_10, bck_prv_st_11
    );
endinterface

// File: rtl/viterbi_acs.sv
// Add-compare-select and survivor storage for a K=3, rate-1/2 hard-decision Viterbi decoder.
// Accepts FRAME symbols, picks the best end state, then replays decisions newest-first.
module viterbi_acs #(
    parameter int FRAME = 8,
    parameter int PM_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    viterbi_acs_if.slave bus
);
    localparam int              PTR_W  = $clog2(FRAME);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(FRAME - 1);
    localparam logic [PM_W-1:0] PM_MAX = '1;

    typedef enum logic [1:0] {ST_ACS, ST_BEST, ST_TBCK} state_t;

    state_t           state, state_next;
    logic             in_ready, en_tbck, accept;
    logic [PM_W-1:0]  pm      [4];
    logic [PM_W-1:0]  pm_next [4];
    logic [1:0]       dec_next [4];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_addr;
    logic [7:0]       surv [FRAME];
    logic [7:0]       rd_data;
    logic [1:0]       best_node;
    logic [PM_W-1:0]  best_pm;
    logic [1:0]       sel_node;
    logic [PM_W-1:0]  best_metric;
    logic [7:0]       bck;

    function automatic logic [1:0] branch_metric(input logic [1:0] sym, input logic [1:0] p,
                                                 input logic u);
        logic [1:0] diff;
        diff = sym ^ {u ^ p[1] ^ p[0], u ^ p[0]};
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
        logic [PM_W:0] sum;
        sum = {1'b0, a} + (PM_W + 1)'(b);
        return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
    endfunction

    // Returns {chosen predecessor, new metric}; strict compare keeps the lower predecessor on ties.
    function automatic logic [PM_W+1:0] acs_node(input logic [1:0] n, input logic [1:0] sym,
                                                 input logic [PM_W-1:0] pm_lo,
                                                 input logic [PM_W-1:0] pm_hi);
        logic [1:0]      p_lo, p_hi;
        logic [PM_W-1:0] c_lo, c_hi;
        p_lo = {n[0], 1'b0};
        p_hi = {n[0], 1'b1};
        c_lo = sat_add(pm_lo, branch_metric(sym, p_lo, n[1]));
        c_hi = sat_add(pm_hi, branch_metric(sym, p_hi, n[1]));
        if (c_hi < c_lo) return {p_hi, c_hi};
        return {p_lo, c_lo};
    endfunction

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            {dec_next[n], pm_next[n]} = acs_node(2'(n), bus.in_sym, pm[(n % 2) * 2],
                                                 pm[(n % 2) * 2 + 1]);
        end
    end

    always_comb begin
        best_node = 2'd0;
        best_pm   = pm[0];
        for (int s = 1; s < 4; s++) begin
            if (pm[s] < best_pm) begin
                best_pm   = pm[s];
                best_node = 2'(s);
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        en_tbck    = 1'b0;
        case (state)
            ST_ACS: begin
                in_ready = 1'b1;
                if (bus.in_valid && wr_ptr == LAST) state_next = ST_BEST;
            end
            ST_BEST: state_next = ST_TBCK;
            ST_TBCK: begin
                en_tbck = 1'b1;
                if (rd_ptr == '0) state_next = ST_ACS;
            end
            default: state_next = ST_ACS;
        endcase
    end

    assign accept  = bus.in_valid & in_ready;
    assign rd_addr = (state == ST_BEST) ? LAST : rd_ptr - 1'b1;
    assign rd_data = surv[rd_addr];

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACS;
        else     state <= state_next;
    end

    // NOTE: survivor RAM has no reset; every entry is written before a replay can read it.
    always_ff @(posedge clk) begin
        if (accept) surv[wr_ptr] <= {dec_next[0], dec_next[1], dec_next[2], dec_next[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pm[0]       <= '0;
            pm[1]       <= PM_MAX;
            pm[2]       <= PM_MAX;
            pm[3]       <= PM_MAX;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sel_node    <= 2'd0;
            best_metric <= '0;
            bck         <= '0;
        end else begin
            case (state)
                ST_ACS: begin
                    if (accept) begin
                        pm     <= pm_next;
                        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                    end
                end
                ST_BEST: begin
                    sel_node    <= best_node;
                    best_metric <= best_pm;
                    rd_ptr      <= LAST;
                    bck         <= rd_data;
                end
                ST_TBCK: begin
                    if (rd_ptr != '0) begin
                        rd_ptr <= rd_ptr - 1'b1;
                        bck    <= rd_data;
                    end else begin
                        // Frame done: metrics restart from the known encoder state 00.
                        pm[0]  <= '0;
                        pm[1]  <= PM_MAX;
                        pm[2]  <= PM_MAX;
                        pm[3]  <= PM_MAX;
                        wr_ptr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.en_tbck       = en_tbck;
    assign bus.sel_node      = sel_node;
    assign bus.best_metric   = best_metric;
    assign bus.bck_prv_st_00 = bck[7:6];
    assign bus.bck_prv_st_01 = bck[5:4];
    assign bus.bck_prv_st_10 = bck[3:2];
    assign bus.bck_prv_st_11 = bck[1:0];
endmodule

// File: tb/tb_viterbi_acs.sv
// Self-checking bench for viterbi_acs: random and directed frames against a trellis-level model.
// Model enumerates every (state, input) transition and keeps the cheapest arrival per state.
module tb_viterbi_acs;
    localparam int FRAME  = 8;
    localparam int PM_W   = 6;
    localparam int PM_MAX = (1 << PM_W) - 1;

    typedef logic [1:0] sym_arr_t [FRAME];
    typedef logic [7:0] dec_arr_t [FRAME];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    viterbi_acs_if #(.PM_W(PM_W)) bus ();

    viterbi_acs #(.FRAME(FRAME), .PM_W(PM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int       total = 0;
    int       bad   = 0;
    dec_arr_t got_dec;

    // Forward trellis walk: each state s with input u reaches {u, s[1]} at Hamming cost.
    function automatic void ref_model(input sym_arr_t syms, output dec_arr_t dec,
                                      output int sel, output int best);
        int pm[4];
        int npm[4];
        int nd[4];
        pm = '{0, PM_MAX, PM_MAX, PM_MAX};
        for (int t = 0; t < FRAME; t++) begin
            for (int n = 0; n < 4; n++) begin
                npm[n] = 1 << 30;
                nd[n]  = 0;
            end
            for (int p = 0; p < 4; p++) begin
                for (int u = 0; u < 2; u++) begin
                    int nxt, cost;
                    bit e0, e1;
                    nxt  = u * 2 + (p / 2);
                    e0   = bit'(u ^ (p / 2) ^ (p % 2));
                    e1   = bit'(u ^ (p % 2));
                    cost = pm[p];
                    if (syms[t][1] != e0) cost++;
                    if (syms[t][0] != e1) cost++;
                    if (cost > PM_MAX) cost = PM_MAX;
                    if (cost < npm[nxt]) begin
                        npm[nxt] = cost;
                        nd[nxt]  = p;
                    end
                end
            end
            pm     = npm;
            dec[t] = {2'(nd[0]), 2'(nd[1]), 2'(nd[2]), 2'(nd[3])};
        end
        sel  = 0;
        best = pm[0];
        for (int s = 1; s < 4; s++) begin
            if (pm[s] < best) begin
                best = pm[s];
                sel  = s;
            end
        end
    endfunction

    // Drives one frame, then checks BEST and every replay cycle; abort_at >= 0 resets mid-TBCK.
    task automatic run_frame(input string name, input sym_arr_t syms, input bit toggle,
                             input int abort_at);
        dec_arr_t exp_dec;
        int       exp_sel, exp_best;
        int       idx = 0;
        int       cyc = 0;
        logic [7:0] obs;
        ref_model(syms, exp_dec, exp_sel, exp_best);
        while (idx < FRAME && cyc < 100) begin
            @(negedge clk);
            cyc++;
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s ready_in_acs got=%b want=1", name, bus.in_ready);
            end
            if (toggle && (cyc % 2 == 1)) begin
                bus.in_valid = 1'b0;
                bus.in_sym   = 2'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_sym   = syms[idx];
                idx++;
            end
        end
        total++;
        if (idx < FRAME) begin
            bad++;
            $display("FAIL %s accept_timeout got=%0d want=%0d", name, idx, FRAME);
        end
        // BEST cycle: symbols offered here and during TBCK must be ignored.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sym   = 2'($urandom);
        total++;
        if ({bus.in_ready, bus.en_tbck} !== 2'b00) begin
            bad++;
            $display("FAIL %s best_cycle ready/en got=%b want=00", name,
                     {bus.in_ready, bus.en_tbck});
        end
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            bus.in_sym = 2'($urandom);
            if (k == abort_at) begin
                rst          = 1'b1;
                bus.in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                total++;
                if ({bus.in_ready, bus.en_tbck, bus.sel_node, bus.best_metric,
                     bus.bck_prv_st_00, bus.bck_prv_st_01, bus.bck_prv_st_10,
                     bus.bck_prv_st_11} !== {2'b10, 2'b00, PM_W'(0), 8'h00}) begin
                    bad++;
                    $display("FAIL %s reset_mid_tbck rdy=%b en=%b sel=%0d best=%0d bck=%h want rdy=1 others 0",
                             name, bus.in_ready, bus.en_tbck, bus.sel_node, bus.best_metric,
                             {bus.bck_prv_st_00, bus.bck_prv_st_01, bus.bck_prv_st_10,
                              bus.bck_prv_st_11});
                end
                return;
            end
            obs = {bus.bck_prv_st_00, bus.bck_prv_st_01, bus.bck_prv_st_10, bus.bck_prv_st_11};
            got_dec[FRAME-1-k] = obs;
            total++;
            if ({bus.in_ready, bus.en_tbck} !== 2'b01) begin
                bad++;
                $display("FAIL %s tbck%0d ready/en got=%b want=01", name, k,
                         {bus.in_ready, bus.en_tbck});
            end
            total++;
            if (bus.sel_node !== 2'(exp_sel) || bus.best_metric !== PM_W'(exp_best)) begin
                bad++;
                $display("FAIL %s tbck%0d sel/best got=%0d/%0d want=%0d/%0d", name, k,
                         bus.sel_node, bus.best_metric, exp_sel, exp_best);
            end
            total++;
            if (obs !== exp_dec[FRAME-1-k]) begin
                bad++;
                $display("FAIL %s tbck%0d decision got=%h want=%h", name, k, obs,
                         exp_dec[FRAME-1-k]);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if ({bus.in_ready, bus.en_tbck} !== 2'b10 || bus.sel_node !== 2'(exp_sel)) begin
            bad++;
            $display("FAIL %s after_tbck ready/en/sel got=%b/%0d want=10/%0d", name,
                     {bus.in_ready, bus.en_tbck}, bus.sel_node, exp_sel);
        end
    endtask

    // Walks the replayed decisions back from state 00 and compares the decoded bits.
    task automatic trace_message(input string name, input logic [FRAME-1:0] msg);
        logic [1:0]       cur = 2'b00;
        logic [FRAME-1:0] decoded;
        logic [7:0]       e;
        for (int t = FRAME - 1; t >= 0; t--) begin
            decoded[t] = cur[1];
            if (t == 0) begin
                total++;
                if (cur !== 2'b10) begin
                    bad++;
                    $display("FAIL %s first_state got=%b want=10", name, cur);
                end
            end
            e   = got_dec[t];
            cur = e[7 - 2 * int'(cur) -: 2];
        end
        total++;
        if (decoded !== msg) begin
            bad++;
            $display("FAIL %s decoded got=%b want=%b", name, decoded, msg);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sym   = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus.in_ready, bus.en_tbck, bus.sel_node, bus.best_metric,
             bus.bck_prv_st_00, bus.bck_prv_st_01, bus.bck_prv_st_10, bus.bck_prv_st_11}
            !== {2'b10, 2'b00, PM_W'(0), 8'h00}) begin
            bad++;
            $display("FAIL reset_values rdy=%b en=%b sel=%0d best=%0d want rdy=1 others 0",
                     bus.in_ready, bus.en_tbck, bus.sel_node, bus.best_metric);
        end
    endtask

    task automatic test_all_zero();
        sym_arr_t syms;
        for (int i = 0; i < FRAME; i++) syms[i] = 2'b00;
        run_frame("all_zero", syms, 1'b0, -1);
    endtask

    task automatic test_message();
        sym_arr_t syms;
        syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
        run_frame("message", syms, 1'b0, -1);
        trace_message("message", 8'b0000_1101);
        syms[2] = 2'b10;
        run_frame("message_err", syms, 1'b0, -1);
        trace_message("message_err", 8'b0000_1101);
    endtask

    task automatic test_tie_break();
        sym_arr_t syms;
        syms[0] = 2'b01;
        for (int i = 1; i < FRAME; i++) syms[i] = 2'($urandom);
        run_frame("tie_break", syms, 1'b0, -1);
        total++;
        if (got_dec[0] !== 8'b00_10_00_10) begin
            bad++;
            $display("FAIL tie_break first_decision got=%h want=22", got_dec[0]);
        end
    endtask

    task automatic test_handshake();
        sym_arr_t syms;
        syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
        run_frame("handshake_msg", syms, 1'b1, -1);
        trace_message("handshake_msg", 8'b0000_1101);
        for (int i = 0; i < FRAME; i++) syms[i] = 2'($urandom);
        run_frame("handshake_rand", syms, 1'b1, -1);
    endtask

    task automatic test_random();
        sym_arr_t syms;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < FRAME; i++) syms[i] = 2'($urandom);
            run_frame($sformatf("random%0d", f), syms, 1'b0, -1);
        end
    endtask

    task automatic test_reset_mid_tbck();
        sym_arr_t syms;
        for (int i = 0; i < FRAME; i++) syms[i] = 2'($urandom_range(1, 3));
        run_frame("mid_tbck", syms, 1'b0, 3);
        for (int i = 0; i < FRAME; i++) syms[i] = 2'b00;
        run_frame("post_reset_zero", syms, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_message();
        test_tie_break();
        test_handshake();
        test_random();
        test_reset_mid_tbck();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
